// File: rtl/store_write_buffer.sv
// Store write buffer for the MEM stage: queues SB/SH/SW and retires them to
// DataMemory in cycles where the port is free. Loads use the port directly
// unless they overlap a buffered store, in which case the pipeline stalls
// until the overlapping entries have drained.
module store_write_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic        DrainReq,
   output logic        StallSB,
   output logic [31:0] ReadDataM,
   output logic        SBEmpty,
   output logic        DM_WE,
   output logic [2:0]  DM_funct3,
   output logic [31:0] DM_A,
   output logic [31:0] DM_WD,
   input  logic [31:0] DM_RD
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [31:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [1:0]    size_q [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic          empty;
   logic          full;
   logic          overlap;
   logic          drain;
   logic          enq;
   logic [PW-1:0] idx;
   logic [31:0]   ld_lo;
   logic [31:0]   ld_hi;

   // Word index of the last byte touched by an access of the given size.
   function automatic logic [31:0] word_hi(input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] last;
      case (sz)
         2'b00:   last = a;
         2'b01:   last = a + 32'd1;
         default: last = a + 32'd3;
      endcase
      return {2'b00, last[31:2]};
   endfunction

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign SBEmpty   = empty;
   assign ReadDataM = DM_RD;
   assign ld_lo     = {2'b00, ALUResultM[31:2]};
   assign ld_hi     = word_hi(ALUResultM, funct3M[1:0]);

   // Does the MEM-stage load touch any word held by a live buffer entry?
   always_comb begin
      overlap = 1'b0;
      idx     = head;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((i < 32'(count)) &&
             (ld_lo <= word_hi(addr_q[idx], size_q[idx])) &&
             ({2'b00, addr_q[idx][31:2]} <= ld_hi)) begin
            overlap = 1'b1;
         end
      end
   end

   // Port arbitration: decide stall, drain or enqueue and drive DataMemory.
   always_comb begin
      StallSB   = 1'b0;
      DM_WE     = 1'b0;
      DM_A      = '0;
      DM_WD     = '0;
      DM_funct3 = '0;
      drain     = 1'b0;
      enq       = 1'b0;
      if (!RST) begin
         if (DrainReq && !empty) begin
            StallSB = 1'b1;
            drain   = 1'b1;
         end else if (MemReadM) begin
            // a simultaneous store request is ignored: the load wins
            if (overlap) begin
               StallSB = 1'b1;
               drain   = 1'b1;
            end else begin
               DM_A      = ALUResultM;
               DM_funct3 = funct3M;
            end
         end else if (MemWriteM && (funct3M[1:0] != 2'b11)) begin
            if (full) begin
               StallSB = 1'b1;
               drain   = 1'b1;
            end else begin
               enq = 1'b1;
            end
         end else if (!empty) begin
            drain = 1'b1;
         end
         if (drain) begin
            DM_WE     = 1'b1;
            DM_A      = addr_q[head];
            DM_WD     = data_q[head];
            DM_funct3 = {1'b0, size_q[head]};
         end
      end
   end

   // Queue storage and pointer/count bookkeeping.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            size_q[i] <= '0;
         end
      end else if (enq) begin
         addr_q[tail] <= ALUResultM;
         data_q[tail] <= WriteDataM;
         size_q[tail] <= funct3M[1:0];
         tail         <= tail + 1'b1;
         count        <= count + 1'b1;
      end else if (drain) begin
         head  <= head + 1'b1;
         count <= count - 1'b1;
      end
   end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- FIFO write buffer in the MEM stage, between the pipeline's memory-access signals and DataMemory.
- Absorbs bursts of SB/SH/SW and retires them to DataMemory in cycles with no MEM-stage memory op.
- Loads take the DataMemory port directly; a load overlapping any buffered store stalls until the overlapping entries drain.
- A drain request, used for fence/ecall, stalls until the buffer is empty.

Parameters:
DEPTH, 4, number of buffered stores (power of 2, ≥2)

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  asynchronous, active-high reset
MemReadM  in  1  load in MEM stage
MemWriteM  in  1  store in MEM stage
funct3M  in  3  load/store funct3
ALUResultM  in  32  effective byte address
WriteDataM  in  32  store data
DrainReq  in  1  hold pipeline until buffer empty
StallSB  out  1  freeze IF..MEM, bubble WB; MEM inputs re-presented next cycle
ReadDataM  out  32  load data to pipeline (= DM_RD)
SBEmpty  out  1  buffer holds no entries
DM_WE  out  1  DataMemory write enable
DM_funct3  out  3  DataMemory funct3
DM_A  out  32  DataMemory address
DM_WD  out  32  DataMemory write data
DM_RD  in  32  DataMemory read data

Behaviour:
- Storage: DEPTH entries of {addr[31:0], data[31:0], size[1:0]}.
- Pointers: head/tail of log2(DEPTH) bits, wrapping modulo DEPTH. Count is 0..DEPTH.
- Reset: while RST is high, all entries invalid, pointers and count 0, SBEmpty=1, StallSB=0, DM_WE=0, DM_A=0, DM_WD=0, DM_funct3=0. Reset discards buffered stores, including mid-drain.
- Byte span of an access: size 00 → 1 byte, 01 → 2, 10 → 4.
- Overlap: the load's word range [A>>2, (A+n-1)>>2] intersects an entry's word range.
- Load (MemReadM=1), evaluated combinationally:
  - No overlap and DrainReq=0: StallSB=0, DM_WE=0, DM_A=ALUResultM, DM_funct3=funct3M, ReadDataM=DM_RD in the same cycle. No drain that cycle.
  - Overlap: StallSB=1 and the head drains this cycle. This repeats while any overlapping entry remains. FIFO order guarantees the youngest matching store is written last.
- Store (MemWriteM=1):
  - funct3M[1:0]=11: dropped, no enqueue, no stall.
  - count<DEPTH at cycle start and DrainReq=0: enqueue at the edge, StallSB=0, no drain.
  - count==DEPTH: StallSB=1, head drains; the store is accepted the next cycle.
- Idle cycle (MemReadM=0, MemWriteM=0) with count>0: drain head. StallSB=0 unless DrainReq=1.
- Drain cycle:
  - DM_WE=1, DM_A=head.addr, DM_WD=head.data, DM_funct3={1'b0, head.size}.
  - Head advances and count decrements at the edge.
  - At most one drain per cycle.
- DrainReq=1:
  - StallSB=1 while count>0, draining each cycle. MEM ops are not performed.
  - When count==0, StallSB=0 and any MEM op proceeds normally that cycle.
- No-drain cycles: DM_WE=0, and DM_A/DM_WD/DM_funct3 are 0 unless a load drives them.
- MemReadM and MemWriteM both high: illegal; treated as a load, store discarded.
- Count never exceeds DEPTH. A simultaneous enqueue and drain cannot occur.
- SBEmpty = (count==0).

Test Plan:
1. Assert RST mid-run with 2 entries → same cycle DM_WE=0, SBEmpty=1, StallSB=0; after release no writes issued.
2. SW 0x10=0xDEADBEEF, then LW 0x40 → no stall, DM_A=0x40, DM_WE=0. Next idle cycle: DM_WE=1, DM_A=0x10, DM_WD=0xDEADBEEF, funct3=010. Then SBEmpty=1.
3. Mem word 0x10 preset 0x00000000; SB 0x13=0xAB, then LW 0x10 → StallSB=1 for one cycle with write A=0x13, WD[7:0]=0xAB, funct3=000. Next cycle ReadDataM=0xAB000000, StallSB=0.
4. SW 0x0..0x10 (step 4) data 1..5 back-to-back:
   - Cycles 1-4: enqueue, no stall.
   - Cycle 5: StallSB=1, write A=0x0, WD=1.
   - Cycle 6: fifth store accepted, count=4.
5. 3 entries (0x20, 0x24, 0x28), DrainReq=1 → StallSB high 3 cycles, writes in order 0x20, 0x24, 0x28, SBEmpty=1 in cycle 4 with StallSB=0.
6. SW 0x30=0x1, then SW 0x30=0x2, then LW 0x30 → stall 2 cycles draining both in order; load returns 0x00000002.
